instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_if.sv | 28 ++
 rtl/instr_mem_loader.sv | 118 +++++++++++
 tb/tb_instr_mem_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus of the loader.
// master: host side (drives bytes, observes writes); slave: loader.
interface instr_mem_loader_if;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;

  modport master (
    output RxData,
    output RxValid,
    input  RxReady,
    input  WE,
    input  WA,
    input  WD
  );

  modport slave (
    input  RxData,
    input  RxValid,
    output RxReady,
    output WE,
    output WA,
    output WD
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Serial program loader: packs bytes into words, writes imem, holds CPU.
// Ports: CLK, RESETn, Start/WordCount, bus (slave), status, Checksum.
module instr_mem_loader #(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                Start,
  input  logic [7:0]          WordCount,
  instr_mem_loader_if.slave   bus,
  output logic                Busy,
  output logic                Done,
  output logic                Error,
  output logic                CPU_RESET,
  output logic [31:0]         Checksum
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;

  logic [7:0]  count;
  logic [7:0]  idx;
  logic [1:0]  bcnt;
  logic [31:0] word;

  logic        wc_ok;
  logic        can_start;
  logic        start_ok;
  logic        start_bad;
  logic        take;
  logic        last;

  assign wc_ok = (WordCount != 8'd0) &&
                 ({24'd0, WordCount} <= DEPTH_U);

  assign can_start = (state == IDLE) ||
                     (state == DONE);

  assign start_ok  = can_start && Start && wc_ok;
  assign start_bad = can_start && Start && !wc_ok;

  assign take = (state == LOAD) && bus.RxValid;
  assign last = (idx == count - 8'd1);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start_ok) nxt = LOAD;
      end
      LOAD: begin
        if (take && bcnt == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        nxt = last ? DONE : LOAD;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count    <= 8'd0;
      idx      <= 8'd0;
      bcnt     <= 2'd0;
      word     <= 32'd0;
      Checksum <= 32'd0;
      Error    <= 1'b0;
    end else begin
      if (start_ok) begin
        count    <= WordCount;
        idx      <= 8'd0;
        bcnt     <= 2'd0;
        Checksum <= 32'd0;
        Error    <= 1'b0;
      end else if (start_bad) begin
        Error <= 1'b1;
      end
      // little-endian: byte n lands in word[8n+7:8n]
      if (take) begin
        word[{bcnt, 3'b000} +: 8] <= bus.RxData;
        bcnt <= bcnt + 2'd1;
      end
      if (state == WRITE) begin
        Checksum <= Checksum + word;
        idx      <= idx + 8'd1;
      end
    end
  end

  assign bus.RxReady = (state == LOAD);
  assign bus.WE      = (state == WRITE);
  assign bus.WA      = BASE_ADDR + {22'd0, idx, 2'b00};
  assign bus.WD      = word;

  assign Busy      = (state == LOAD) || (state == WRITE);
  assign Done      = (state == DONE);
  assign CPU_RESET = (state != DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Directed scenarios with random bytes/gaps against a word-level model.
module tb_instr_mem_loader;

  logic        CLK;
  logic        RESETn;
  logic        Start;
  logic [7:0]  WordCount;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic        CPU_RESET;
  logic [31:0] Checksum;

  instr_mem_loader_if bus ();

  instr_mem_loader dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .Start     (Start),
    .WordCount (WordCount),
    .bus       (bus),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .CPU_RESET (CPU_RESET),
    .Checksum  (Checksum)
  );

  int checks   = 0;
  int failures = 0;
  int hs       = 0;

  logic [7:0]  q[$];
  logic [63:0] wlog[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every WE cycle must follow a whole number of words.
  always @(negedge CLK) begin
    if (!RESETn) begin
      hs = 0;
    end else begin
      if (bus.WE) begin
        wlog.push_back({bus.WA, bus.WD});
        chk("we_mid_word", 64'(hs % 4 == 0 && hs > 0), 64'd1);
      end
      if (bus.RxValid && bus.RxReady) hs++;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) cyc();
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.RxReady) begin
        cyc();
        ok = 1'b1;
        break;
      end
      cyc();
    end
    bus.RxValid = 1'b0;
    bus.RxData  = 8'($urandom);
    if (!ok) chk("rx_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start(input logic [7:0] n);
    Start     = 1'b1;
    WordCount = n;
    cyc();
    Start     = 1'b0;
    WordCount = 8'($urandom);
  endtask

  task automatic fill_rand(input int n);
    q.delete();
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
  endtask

  // Loads q as n words; the model derives writes from the byte list.
  task automatic do_load(input int n, input int maxgap);
    logic [31:0] w;
    logic [31:0] sum;
    wlog.delete();
    pulse_start(8'(n));
    chk("st_busy", 64'(Busy), 64'd1);
    chk("st_done", 64'(Done), 64'd0);
    chk("st_err", 64'(Error), 64'd0);
    chk("st_cpurst", 64'(CPU_RESET), 64'd1);
    for (int i = 0; i < 4 * n; i++)
      send_byte(q[i], $urandom_range(0, maxgap));
    chk("lat_we", 64'(bus.WE), 64'd1);
    cyc();
    chk("lat_done", 64'(Done), 64'd1);
    chk("end_cpurst", 64'(CPU_RESET), 64'd0);
    chk("end_busy", 64'(Busy), 64'd0);
    chk("n_writes", 64'(wlog.size()), 64'(n));
    sum = 32'd0;
    for (int k = 0; k < n; k++) begin
      w = {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]};
      sum += w;
      if (k < wlog.size()) begin
        chk("wa", 64'(wlog[k][63:32]), 64'(4 * k));
        chk("wd", 64'(wlog[k][31:0]), 64'(w));
      end
    end
    chk("checksum", 64'(Checksum), 64'(sum));
  endtask

  task automatic check_idle_err();
    chk("err_set", 64'(Error), 64'd1);
    chk("err_busy", 64'(Busy), 64'd0);
    chk("err_cpurst", 64'(CPU_RESET), 64'd1);
  endtask

  initial begin
    RESETn      = 1'b0;
    Start       = 1'b0;
    WordCount   = 8'd0;
    bus.RxData  = 8'd0;
    bus.RxValid = 1'b0;
    #3;
    chk("rst_rdy", 64'(bus.RxReady), 64'd0);
    chk("rst_we", 64'(bus.WE), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_err", 64'(Error), 64'd0);
    chk("rst_cpurst", 64'(CPU_RESET), 64'd1);
    chk("rst_csum", 64'(Checksum), 64'd0);
    #14;
    RESETn = 1'b1;
    cyc();
    cyc();
    chk("idle_rdy", 64'(bus.RxReady), 64'd0);

    // two-word directed load
    q = '{8'h00, 8'h00, 8'h00, 8'hE2,
          8'h01, 8'h10, 8'h80, 8'hE2};
    do_load(2, 0);
    chk("d_wd0", 64'(wlog[0][31:0]), 64'hE200_0000);
    chk("d_wd1", 64'(wlog[1][31:0]), 64'hE280_1001);
    chk("d_csum", 64'(Checksum), 64'hC480_1001);

    // same stream, 3 idle cycles between bytes
    wlog.delete();
    pulse_start(8'd2);
    for (int i = 0; i < 8; i++) send_byte(q[i], 3);
    cyc();
    chk("bp_n", 64'(wlog.size()), 64'd2);
    chk("bp_w0", wlog[0], {32'h0, 32'hE200_0000});
    chk("bp_w1", wlog[1], {32'h4, 32'hE280_1001});
    chk("bp_done", 64'(Done), 64'd1);

    // bad count in DONE: error only, CPU stays released
    pulse_start(8'd0);
    chk("derr_set", 64'(Error), 64'd1);
    chk("derr_done", 64'(Done), 64'd1);
    chk("derr_cpurst", 64'(CPU_RESET), 64'd0);

    // invalid counts from IDLE
    RESETn = 1'b0;
    #7;
    RESETn = 1'b1;
    cyc();
    wlog.delete();
    pulse_start(8'd0);
    check_idle_err();
    repeat (3) cyc();
    pulse_start(8'd129);
    check_idle_err();
    repeat (3) cyc();
    chk("err_no_we", 64'(wlog.size()), 64'd0);
    chk("err_hold", 64'(Error), 64'd1);
    fill_rand(1);
    do_load(1, 2);

    // full-depth load with random bytes and gaps
    fill_rand(128);
    do_load(128, 1);
    chk("full_last_wa", 64'(wlog[127][63:32]), 64'h1FC);

    // reset in the middle of word 1; Start ignored in LOAD
    fill_rand(2);
    pulse_start(8'd2);
    Start     = 1'b1;
    WordCount = 8'd0;
    cyc();
    Start = 1'b0;
    chk("load_ign_err", 64'(Error), 64'd0);
    chk("load_ign_busy", 64'(Busy), 64'd1);
    for (int i = 0; i < 6; i++) send_byte(q[i], 0);
    #2;
    RESETn = 1'b0;
    #1;
    chk("mr_we", 64'(bus.WE), 64'd0);
    chk("mr_cpurst", 64'(CPU_RESET), 64'd1);
    chk("mr_csum", 64'(Checksum), 64'd0);
    chk("mr_busy", 64'(Busy), 64'd0);
    chk("mr_wd", 64'(bus.WD), 64'd0);
    #10;
    RESETn = 1'b1;
    cyc();
    fill_rand(2);
    do_load(2, 1);

    // reload from DONE
    fill_rand(1);
    do_load(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
